instruction_fetch_unit: RTL

- Fetch stage of the pipelined core. Issues single-outstanding instruction reads to instruction memory over a request/ack handshake and tracks the PC.
- Owns the IF/ID pipeline register, whose instruction word feeds the decoder and control unit (opcode/funct3/funct7).
- Absorbs decode stalls with a one-entry skid buffer and services redirects (branches, jumps, traps, xRET) without losing or duplicating instructions.

---
 rtl/instruction_fetch_unit.sv | 104 ++++++++++
 1 files changed

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: single-outstanding instruction fetch with PC tracking, IF/ID register and one-entry skid buffer.
module instruction_fetch_unit #(
  parameter int DATA_SIZE = 64,
  parameter logic [DATA_SIZE-1:0] RESET_PC = '0
) (
  input  logic                 clock,
  input  logic                 reset,
  output logic                 mem_rd_en,
  output logic [DATA_SIZE-1:0] mem_addr,
  input  logic                 mem_ack,
  input  logic [31:0]          mem_rd_dat,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 new_pc_en,
  input  logic [DATA_SIZE-1:0] new_pc,
  output logic                 if_id_valid,
  output logic [31:0]          if_id_inst,
  output logic [DATA_SIZE-1:0] if_id_pc,
  output logic [DATA_SIZE-1:0] if_id_pc_plus4
);
  typedef enum logic [1:0] {FETCH, FULL, DISCARD} state_t;
  localparam logic [31:0] NOP = 32'h0000_0013;
  state_t state, state_n;
  logic [DATA_SIZE-1:0] pc, pc_n, pc4, pending, pending_n, skid_pc, load_pc;
  logic [31:0] skid_inst, load_inst;
  logic skid_we, load;
  assign pc4 = pc + DATA_SIZE'(4);
  assign mem_rd_en = !reset && state != FULL;
  assign mem_addr = pc;
  always_comb begin
    state_n = state;
    pc_n = pc;
    pending_n = pending;
    skid_we = 1'b0;
    load = 1'b0;
    load_inst = mem_rd_dat;
    load_pc = pc;
    case (state)
      FETCH:
        if (mem_ack) begin
          if (new_pc_en) pc_n = new_pc;
          else begin
            pc_n = pc4;
            if (if_id_valid && stall) begin
              skid_we = 1'b1;
              state_n = FULL;
            end else load = 1'b1;
          end
        end else if (new_pc_en) begin
          pending_n = new_pc;
          state_n = DISCARD;
        end
      FULL:
        if (new_pc_en) begin
          pc_n = new_pc;
          state_n = FETCH;
        end else if (!stall) begin
          load = 1'b1;
          load_inst = skid_inst;
          load_pc = skid_pc;
          state_n = FETCH;
        end
      DISCARD:
        // the last redirect wins, including one coincident with the ack
        if (mem_ack) begin
          pc_n = new_pc_en ? new_pc : pending;
          state_n = FETCH;
        end else if (new_pc_en) pending_n = new_pc;
      default: state_n = FETCH;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= FETCH;
      pc <= RESET_PC;
      pending <= RESET_PC;
      skid_inst <= NOP;
      skid_pc <= '0;
      if_id_valid <= 1'b0;
      if_id_inst <= NOP;
      if_id_pc <= '0;
      if_id_pc_plus4 <= DATA_SIZE'(4);
    end else begin
      state <= state_n;
      pc <= pc_n;
      pending <= pending_n;
      if (skid_we) begin
        skid_inst <= mem_rd_dat;
        skid_pc <= pc;
      end
      if (new_pc_en || flush) begin
        if_id_valid <= 1'b0;
        if_id_inst <= NOP;
      end else if (!(stall && if_id_valid)) begin
        if_id_valid <= load;
        if (load) begin
          if_id_inst <= load_inst;
          if_id_pc <= load_pc;
          if_id_pc_plus4 <= load_pc + DATA_SIZE'(4);
        end
      end
    end
  end
endmodule
